// File: rtl/frame_tx_seq_if.sv
// frame_tx_seq_if: payload handshake and sequencer control bundle
interface frame_tx_seq_if #(
  parameter int ADDR_W = 3,
  parameter int LEN_W = 11
);
  logic VALID;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [1:0] MUX_SEL;
  logic CLR_CRC;
  logic CRC_DV;
  logic TX_ACK;
  logic TRUNC;
  logic [LEN_W-1:0] FRM_LEN;
  logic [2:0] FRM_STATE;
  logic BUSY;
  modport master (
    input VALID,
    output ROM_ADDR, MUX_SEL, CLR_CRC, CRC_DV, TX_ACK, TRUNC, FRM_LEN, FRM_STATE, BUSY
  );
  modport slave (
    output VALID,
    input ROM_ADDR, MUX_SEL, CLR_CRC, CRC_DV, TX_ACK, TRUNC, FRM_LEN, FRM_STATE, BUSY
  );
endinterface

// File: rtl/frame_tx_seq.sv
// frame_tx_seq: wraps payload bursts with ROM header/trailer and a CRC slot; define FRAME_TMR_EN for triplicated registers
module frame_tx_seq #(
  parameter int ADDR_W = 3,
  parameter int HDR_WORDS = 5,
  parameter int CRC_WORDS = 1,
  parameter int TRL_WORDS = 2,
  parameter int IFG = 2,
  parameter int MAX_LEN = 1024,
  parameter int LEN_W = 11
) (
  input logic CLK,
  input logic RST,
  frame_tx_seq_if.master bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, HDR = 3'd1, SOF = 3'd2, DATA = 3'd3, CRC = 3'd4, TRL = 3'd5, GAP = 3'd6
  } state_t;
  localparam int SW = ADDR_W + LEN_W;
  typedef struct packed {
    logic [SW-1:0] sub;
    logic [LEN_W-1:0] cnt;
    logic drain;
    logic [ADDR_W-1:0] rom_addr;
    logic [1:0] mux_sel;
    logic clr_crc;
    logic crc_dv;
    logic tx_ack;
    logic trunc;
    logic busy;
    logic [LEN_W-1:0] frm_len;
    logic [2:0] frm_state;
  } regs_t;
  logic [2:0] cs, ns, start;
  regs_t c, n;
  logic hold, full;
  logic [SW-1:0] base;
  // next state and next register image, always derived from the (voted) current values
  always_comb begin
    hold = c.drain && bus.VALID;
    full = c.cnt == LEN_W'(MAX_LEN);
    start = bus.VALID ? HDR : IDLE;
    case (cs)
      IDLE: ns = start;
      HDR: ns = c.sub == SW'(HDR_WORDS - 2) ? SOF : HDR;
      SOF: ns = DATA;
      DATA: ns = !bus.VALID || full ? CRC : DATA;
      CRC: ns = c.sub == SW'(CRC_WORDS - 1) ? TRL : CRC;
      TRL: ns = c.sub != SW'(TRL_WORDS - 1) ? TRL : (IFG > 0 || hold) ? GAP : start;
      GAP: ns = (hold || c.sub + SW'(1) < SW'(IFG)) ? GAP : start;
      default: ns = IDLE;
    endcase
    n.sub = ns == cs && (cs == HDR || cs == CRC || cs == TRL || (cs == GAP && !hold)) ? c.sub + SW'(1) : '0;
    n.cnt = ns == DATA ? (cs == DATA ? c.cnt + LEN_W'(1) : LEN_W'(1)) : '0;
    n.trunc = cs == DATA && bus.VALID && full;
    n.drain = n.trunc || hold;
    n.frm_len = cs == DATA && ns != DATA ? c.cnt : c.frm_len;
    base = ns == SOF ? SW'(HDR_WORDS - 1) : ns == TRL ? SW'(HDR_WORDS) : '0;
    n.rom_addr = ns == HDR || ns == SOF || ns == TRL ? ADDR_W'(n.sub + base) : '0;
    n.mux_sel = ns == DATA ? 2'd1 : ns == CRC ? 2'd2 : 2'd0;
    n.clr_crc = ns == HDR || ns == SOF;
    n.crc_dv = ns == DATA;
    n.tx_ack = ns == SOF;
    n.busy = ns != IDLE;
    n.frm_state = ns;
  end
`ifdef FRAME_TMR_EN
  logic [2:0] st0, st1, st2;
  regs_t r0, r1, r2;
  assign cs = (st0 & st1) | (st0 & st2) | (st1 & st2);
  assign c = (r0 & r1) | (r0 & r2) | (r1 & r2);
  // three copies all reload from the voted next value, so one upset copy heals on the next edge
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      st0 <= IDLE;
      st1 <= IDLE;
      st2 <= IDLE;
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
    end else begin
      st0 <= ns;
      st1 <= ns;
      st2 <= ns;
      r0 <= n;
      r1 <= n;
      r2 <= n;
    end
`else
  logic [2:0] st;
  regs_t r;
  assign cs = st;
  assign c = r;
  // state and registered outputs advance together
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      st <= IDLE;
      r <= '0;
    end else begin
      st <= ns;
      r <= n;
    end
`endif
  assign bus.ROM_ADDR = c.rom_addr;
  assign bus.MUX_SEL = c.mux_sel;
  assign bus.CLR_CRC = c.clr_crc;
  assign bus.CRC_DV = c.crc_dv;
  assign bus.TX_ACK = c.tx_ack;
  assign bus.TRUNC = c.trunc;
  assign bus.FRM_LEN = c.frm_len;
  assign bus.FRM_STATE = c.frm_state;
  assign bus.BUSY = c.busy;
endmodule

// File: tb/tb_frame_tx_seq.sv
// tb_frame_tx_seq: directed checks of header/payload/trailer sequencing, truncation, IFG and reset
module tb_frame_tx_seq;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  frame_tx_seq_if bd ();
  frame_tx_seq_if bt ();
  frame_tx_seq_if bz ();
  frame_tx_seq dut (.CLK(CLK), .RST(RST), .bus(bd));
  frame_tx_seq #(.MAX_LEN(4)) dut_t (.CLK(CLK), .RST(RST), .bus(bt));
  frame_tx_seq #(.IFG(0)) dut_z (.CLK(CLK), .RST(RST), .bus(bz));

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // expected {state, rom_addr, mux_sel, clr_crc, crc_dv, tx_ack, trunc, busy} for a state code
  function automatic logic [12:0] ev(input int s, input int a, input logic t);
    return {3'(s), 3'(a), (s == 3) ? 2'd1 : (s == 4) ? 2'd2 : 2'd0, s == 1 || s == 2, s == 3, s == 2, t, s != 0};
  endfunction

  function automatic logic [12:0] od();
    return {bd.FRM_STATE, bd.ROM_ADDR, bd.MUX_SEL, bd.CLR_CRC, bd.CRC_DV, bd.TX_ACK, bd.TRUNC, bd.BUSY};
  endfunction

  function automatic logic [12:0] ot();
    return {bt.FRM_STATE, bt.ROM_ADDR, bt.MUX_SEL, bt.CLR_CRC, bt.CRC_DV, bt.TX_ACK, bt.TRUNC, bt.BUSY};
  endfunction

  function automatic logic [12:0] oz();
    return {bz.FRM_STATE, bz.ROM_ADDR, bz.MUX_SEL, bz.CLR_CRC, bz.CRC_DV, bz.TX_ACK, bz.TRUNC, bz.BUSY};
  endfunction

  task automatic test_reset();
    bd.VALID = 1'b1;
    repeat (3) step();
    n_chk++;
    if (od() !== 13'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", od()); end
    n_chk++;
    if (bd.FRM_LEN !== 11'd0) begin n_fail++; $display("FAIL reset_frm_len: got %0d expected 0", bd.FRM_LEN); end
    n_chk++;
    if (bt.BUSY !== 1'b0 || bz.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy_other: got %b%b expected 00", bt.BUSY, bz.BUSY); end
    bd.VALID = 1'b0;
    RST = 1'b0;
    step();
    n_chk++;
    if (od() !== 13'd0) begin n_fail++; $display("FAIL reset_idle: got %h expected 0", od()); end
  endtask

  task automatic test_basic();
    int e_st[14] = '{1, 1, 1, 1, 2, 3, 3, 3, 4, 5, 5, 6, 6, 0};
    int e_ad[14] = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 5, 6, 0, 0, 0};
    bd.VALID = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      if (k == 7) bd.VALID = 1'b0;
      n_chk++;
      if (od() !== ev(e_st[k], e_ad[k], 1'b0)) begin
        n_fail++;
        $display("FAIL basic cycle %0d: got %h expected %h", k, od(), ev(e_st[k], e_ad[k], 1'b0));
      end
      if (k == 7) begin
        n_chk++;
        if (bd.FRM_LEN !== 11'd0) begin n_fail++; $display("FAIL basic_len_in_data: got %0d expected 0", bd.FRM_LEN); end
      end
      if (k == 8) begin
        n_chk++;
        if (bd.FRM_LEN !== 11'd3) begin n_fail++; $display("FAIL basic_len_load: got %0d expected 3", bd.FRM_LEN); end
      end
    end
    n_chk++;
    if (bd.FRM_LEN !== 11'd3) begin n_fail++; $display("FAIL basic_len_hold: got %0d expected 3", bd.FRM_LEN); end
  endtask

  task automatic test_single();
    int e_st[12] = '{1, 1, 1, 1, 2, 3, 4, 5, 5, 6, 6, 0};
    int e_ad[12] = '{0, 1, 2, 3, 4, 0, 0, 5, 6, 0, 0, 0};
    bd.VALID = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 0) bd.VALID = 1'b0;
      n_chk++;
      if (od() !== ev(e_st[k], e_ad[k], 1'b0)) begin
        n_fail++;
        $display("FAIL single cycle %0d: got %h expected %h", k, od(), ev(e_st[k], e_ad[k], 1'b0));
      end
      if (k == 6) begin
        n_chk++;
        if (bd.FRM_LEN !== 11'd1) begin n_fail++; $display("FAIL single_len: got %0d expected 1", bd.FRM_LEN); end
      end
    end
  endtask

  task automatic test_trunc();
    int e_st[20] = '{1, 1, 1, 1, 2, 3, 3, 3, 3, 4, 5, 5, 6, 6, 6, 6, 6, 0, 0, 0};
    int e_ad[20] = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0};
    bt.VALID = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 15) bt.VALID = 1'b0;
      n_chk++;
      if (ot() !== ev(e_st[k], e_ad[k], k == 9)) begin
        n_fail++;
        $display("FAIL trunc cycle %0d: got %h expected %h", k, ot(), ev(e_st[k], e_ad[k], k == 9));
      end
      if (k == 8) begin
        n_chk++;
        if (bt.FRM_LEN !== 11'd0) begin n_fail++; $display("FAIL trunc_len_pre: got %0d expected 0", bt.FRM_LEN); end
      end
      if (k == 9) begin
        n_chk++;
        if (bt.FRM_LEN !== 11'd4) begin n_fail++; $display("FAIL trunc_len: got %0d expected 4", bt.FRM_LEN); end
      end
    end
  endtask

  task automatic test_ifg0();
    int e_st[19] = '{1, 1, 1, 1, 2, 3, 4, 5, 5, 1, 1, 1, 1, 2, 3, 4, 5, 5, 0};
    int e_ad[19] = '{0, 1, 2, 3, 4, 0, 0, 5, 6, 0, 1, 2, 3, 4, 0, 0, 5, 6, 0};
    bz.VALID = 1'b1;
    for (int k = 0; k < 19; k++) begin
      step();
      if (k == 5 || k == 9) bz.VALID = 1'b0;
      if (k == 8) bz.VALID = 1'b1;
      n_chk++;
      if (oz() !== ev(e_st[k], e_ad[k], 1'b0)) begin
        n_fail++;
        $display("FAIL ifg0 cycle %0d: got %h expected %h", k, oz(), ev(e_st[k], e_ad[k], 1'b0));
      end
    end
    n_chk++;
    if (bz.FRM_LEN !== 11'd1) begin n_fail++; $display("FAIL ifg0_len: got %0d expected 1", bz.FRM_LEN); end
  endtask

  task automatic test_reset_mid();
    bd.VALID = 1'b1;
    repeat (7) step();
    n_chk++;
    if (od() !== ev(3, 0, 1'b0)) begin n_fail++; $display("FAIL rstmid_pre: got %h expected %h", od(), ev(3, 0, 1'b0)); end
    #2;
    RST = 1'b1;
    #1;
    n_chk++;
    if (od() !== 13'd0) begin n_fail++; $display("FAIL rstmid_async: got %h expected 0", od()); end
    n_chk++;
    if (bd.FRM_LEN !== 11'd0) begin n_fail++; $display("FAIL rstmid_len: got %0d expected 0", bd.FRM_LEN); end
    bd.VALID = 1'b0;
    step();
    RST = 1'b0;
    step();
    n_chk++;
    if (od() !== 13'd0) begin n_fail++; $display("FAIL rstmid_idle: got %h expected 0", od()); end
    bd.VALID = 1'b1;
    step();
    n_chk++;
    if (od() !== ev(1, 0, 1'b0)) begin n_fail++; $display("FAIL rstmid_hdr0: got %h expected %h", od(), ev(1, 0, 1'b0)); end
    bd.VALID = 1'b0;
    step();
    n_chk++;
    if (od() !== ev(1, 1, 1'b0)) begin n_fail++; $display("FAIL rstmid_hdr1: got %h expected %h", od(), ev(1, 1, 1'b0)); end
    repeat (10) step();
    n_chk++;
    if (od() !== 13'd0 || bd.FRM_LEN !== 11'd1) begin
      n_fail++;
      $display("FAIL rstmid_done: got %h len %0d expected 0 len 1", od(), bd.FRM_LEN);
    end
  endtask

  task automatic test_illegal();
    bd.VALID = 1'b1;
    step();
    step();
    n_chk++;
    if (od() !== ev(1, 1, 1'b0)) begin n_fail++; $display("FAIL illegal_pre: got %h expected %h", od(), ev(1, 1, 1'b0)); end
`ifdef FRAME_TMR_EN
    force dut.st1 = 3'd7;
    step();
    n_chk++;
    if (od() !== ev(1, 2, 1'b0)) begin n_fail++; $display("FAIL tmr_masked: got %h expected %h", od(), ev(1, 2, 1'b0)); end
    release dut.st1;
    bd.VALID = 1'b0;
    step();
    n_chk++;
    if (od() !== ev(1, 3, 1'b0)) begin n_fail++; $display("FAIL tmr_next: got %h expected %h", od(), ev(1, 3, 1'b0)); end
    n_chk++;
    if (dut.st1 !== 3'd1) begin n_fail++; $display("FAIL tmr_heal: got %0d expected 1", dut.st1); end
    repeat (12) step();
    n_chk++;
    if (od() !== 13'd0) begin n_fail++; $display("FAIL tmr_done: got %h expected 0", od()); end
`else
    force dut.st = 3'd7;
    step();
    n_chk++;
    if (od() !== 13'd0) begin n_fail++; $display("FAIL illegal_to_idle: got %h expected 0", od()); end
    release dut.st;
    bd.VALID = 1'b0;
    step();
    n_chk++;
    if (od() !== 13'd0) begin n_fail++; $display("FAIL illegal_stays_idle: got %h expected 0", od()); end
    n_chk++;
    if (bd.FRM_LEN !== 11'd1) begin n_fail++; $display("FAIL illegal_len: got %0d expected 1", bd.FRM_LEN); end
`endif
  endtask

  initial begin
    bd.VALID = 1'b0;
    bt.VALID = 1'b0;
    bz.VALID = 1'b0;
    test_reset();
    test_basic();
    test_single();
    test_trunc();
    test_ifg0();
    test_reset_mid();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
